// File: rtl/qif_spike_monitor.sv
// QIF spike monitor: detects spike events, measures inter-spike intervals
// into a show-ahead FIFO and reports a per-window spike rate.
module qif_spike_monitor #(
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int WINDOW     = 256,
    parameter int RATE_W     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          spike_in,
    output logic [CNT_W-1:0]              isi_data,
    output logic                          isi_valid,
    input  logic                          isi_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [RATE_W-1:0]             rate,
    output logic                          rate_valid
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int WW = $clog2(WINDOW);
    localparam logic [CNT_W-1:0] ISI_MAX  = '1;
    localparam logic [PW:0]      DEPTH_C  = (PW+1)'(FIFO_DEPTH);
    localparam logic [WW-1:0]    WIN_LAST = WW'(WINDOW-1);

    logic                spike_d_q, spike_d_d;
    logic                first_seen_q, first_seen_d;
    logic [CNT_W-1:0]    isi_cnt_q, isi_cnt_d;
    logic [CNT_W-1:0]    mem_q [FIFO_DEPTH];
    logic [CNT_W-1:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PW:0]         count_q, count_d;
    logic                overflow_q, overflow_d;
    logic [WW-1:0]       win_cnt_q, win_cnt_d;
    logic [RATE_W-1:0]   spike_cnt_q, spike_cnt_d;
    logic [RATE_W-1:0]   rate_q, rate_d;
    logic                rate_valid_q, rate_valid_d;

    logic                evt;
    logic                push, pop, full, do_push;
    logic [RATE_W:0]     spike_sum;
    logic [RATE_W-1:0]   spike_sat;

    assign isi_data   = mem_q[rd_ptr_q];
    assign isi_valid  = (count_q != '0);
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign rate       = rate_q;
    assign rate_valid = rate_valid_q;

    // Rising-edge event detect and saturating interval counter
    always_comb begin
        evt          = en & spike_in & ~spike_d_q;
        spike_d_d    = spike_in;
        first_seen_d = first_seen_q | evt;
        isi_cnt_d    = isi_cnt_q;
        if (evt) begin
            isi_cnt_d = CNT_W'(1);
        end else if (en && isi_cnt_q != ISI_MAX) begin
            isi_cnt_d = isi_cnt_q + CNT_W'(1);
        end
    end

    // ISI FIFO: push on every event after the first, drop when full without pop
    always_comb begin
        push       = evt & first_seen_q;
        pop        = isi_valid & isi_ready;
        full       = (count_q == DEPTH_C);
        do_push    = push & (~full | pop);
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = isi_cnt_q;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (do_push && !pop) begin
            count_d = count_q + (PW+1)'(1);
        end else if (!do_push && pop) begin
            count_d = count_q - (PW+1)'(1);
        end
        if (push && full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    // Rate window: count events over WINDOW enabled cycles, publish at wrap
    always_comb begin
        spike_sum    = {1'b0, spike_cnt_q} + {{RATE_W{1'b0}}, evt};
        spike_sat    = spike_sum[RATE_W] ? '1 : spike_sum[RATE_W-1:0];
        win_cnt_d    = win_cnt_q;
        spike_cnt_d  = spike_cnt_q;
        rate_d       = rate_q;
        rate_valid_d = 1'b0;
        if (en) begin
            if (win_cnt_q == WIN_LAST) begin
                win_cnt_d    = '0;
                spike_cnt_d  = '0;
                rate_d       = spike_sat;
                rate_valid_d = 1'b1;
            end else begin
                win_cnt_d   = win_cnt_q + WW'(1);
                spike_cnt_d = spike_sat;
            end
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spike_d_q    <= 1'b0;
            first_seen_q <= 1'b0;
            isi_cnt_q    <= '0;
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            win_cnt_q    <= '0;
            spike_cnt_q  <= '0;
            rate_q       <= '0;
            rate_valid_q <= 1'b0;
        end else begin
            spike_d_q    <= spike_d_d;
            first_seen_q <= first_seen_d;
            isi_cnt_q    <= isi_cnt_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            win_cnt_q    <= win_cnt_d;
            spike_cnt_q  <= spike_cnt_d;
            rate_q       <= rate_d;
            rate_valid_q <= rate_valid_d;
        end
    end

endmodule

// File: tb/tb_qif_spike_monitor.sv
// Bench for qif_spike_monitor: scoreboard of expected ISIs plus a
// window-rate model, checked every cycle, with directed end-of-test checks.
module tb_qif_spike_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       spike_in = 1'b0;
    logic       isi_ready = 1'b0;
    logic [7:0] isi_data;
    logic       isi_valid;
    logic [2:0] fifo_count;
    logic       overflow;
    logic [7:0] rate;
    logic       rate_valid;

    qif_spike_monitor #(
        .CNT_W(8), .FIFO_DEPTH(4), .WINDOW(256), .RATE_W(8)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .spike_in(spike_in),
        .isi_data(isi_data), .isi_valid(isi_valid),
        .isi_ready(isi_ready), .fifo_count(fifo_count),
        .overflow(overflow), .rate(rate), .rate_valid(rate_valid)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int sb[$];
    int got[$];
    int pulse_t[$];
    bit m_prev, m_first, m_ovf, exp_rv;
    int ecyc, last_e, wcnt, scnt, m_rate;
    int tcnt = 0;
    int pulses = 0;
    int pops = 0;
    int pops0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int gv(input int i);
        if (i < got.size()) return got[i];
        return -1;
    endfunction

    task automatic model_clear();
        sb.delete();
        m_prev = 0; m_first = 0; m_ovf = 0; exp_rv = 0;
        ecyc = 0; last_e = 0; wcnt = 0; scnt = 0; m_rate = 0;
    endtask

    task automatic tick();
        bit evt;
        bit pop;
        int isi;
        exp_rv = 0;
        if (rst) begin
            pop = isi_valid && isi_ready;
            if (pop) begin
                if (sb.size() == 0) begin
                    chk("pop_empty", 32'(isi_valid), 0);
                end else begin
                    isi = sb.pop_front();
                    chk("isi_data", 32'(isi_data), isi);
                    got.push_back(int'(isi_data));
                    pops++;
                end
            end
            evt = en && spike_in && !m_prev;
            if (evt) begin
                if (m_first) begin
                    isi = ecyc - last_e;
                    if (isi > 255) isi = 255;
                    if (sb.size() == 4) m_ovf = 1;
                    else sb.push_back(isi);
                end
                m_first = 1;
                last_e = ecyc;
            end
            if (en) begin
                if (wcnt == 255) begin
                    m_rate = scnt + int'(evt);
                    if (m_rate > 255) m_rate = 255;
                    scnt = 0;
                    wcnt = 0;
                    exp_rv = 1;
                end else begin
                    wcnt++;
                    scnt = scnt + int'(evt);
                    if (scnt > 255) scnt = 255;
                end
                ecyc++;
            end
            m_prev = spike_in;
        end
        @(posedge clk);
        #1;
        tcnt++;
        if (rst) begin
            chk("fifo_count", 32'(fifo_count), sb.size());
            chk("isi_valid", 32'(isi_valid), 32'(sb.size() != 0));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("rate_valid", 32'(rate_valid), 32'(exp_rv));
            chk("rate", 32'(rate), m_rate);
            if (rate_valid) begin
                pulses++;
                pulse_t.push_back(tcnt);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic spikes(input int n, input int spacing);
        for (int k = 0; k < n; k++) begin
            spike_in = 1'b1;
            repeat (3) tick();
            spike_in = 1'b0;
            repeat (spacing - 3) tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_valid", 32'(isi_valid), 0);
        chk("rst_data", 32'(isi_data), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_rate", 32'(rate), 0);
        chk("rst_rv", 32'(rate_valid), 0);
        model_clear();
        repeat (2) tick();
        rst = 1'b1;
    endtask

    initial begin
        model_clear();
        #2;
        do_reset();
        en = 1'b1;
        isi_ready = 1'b1;

        // rises at cycles 10, 25, 45
        got.delete();
        idle(10);
        spikes(1, 15);
        spikes(1, 20);
        spikes(1, 10);
        chk("t1_n", got.size(), 2);
        chk("t1_isi0", gv(0), 15);
        chk("t1_isi1", gv(1), 20);

        // 300-cycle gap saturates
        got.delete();
        spikes(1, 300);
        spikes(1, 10);
        chk("t2_n", got.size(), 2);
        chk("t2_sat", gv(1), 255);

        // overflow with consumer stalled
        do_reset();
        isi_ready = 1'b0;
        spikes(7, 10);
        chk("t3_count", 32'(fifo_count), 4);
        chk("t3_ovf", 32'(overflow), 1);
        got.delete();
        isi_ready = 1'b1;
        idle(6);
        chk("t3_n", got.size(), 4);
        for (int i = 0; i < 4; i++) chk("t3_drain", gv(i), 10);
        chk("t3_ovf_sticky", 32'(overflow), 1);

        // full FIFO, simultaneous push and pop
        do_reset();
        isi_ready = 1'b0;
        spikes(5, 10);
        idle(2);
        chk("t4_full", 32'(fifo_count), 4);
        got.delete();
        spike_in = 1'b1;
        isi_ready = 1'b1;
        tick();
        isi_ready = 1'b0;
        chk("t4_count", 32'(fifo_count), 4);
        chk("t4_ovf", 32'(overflow), 0);
        tick();
        tick();
        spike_in = 1'b0;
        idle(5);
        isi_ready = 1'b1;
        idle(6);
        chk("t4_n", got.size(), 5);
        for (int i = 0; i < 4; i++) chk("t4_old", gv(i), 10);
        chk("t4_new", gv(4), 12);

        // rate window
        do_reset();
        pulses = 0;
        pulse_t.delete();
        spikes(48, 16);
        chk("t5_pulses", pulses, 3);
        chk("t5_gap0", pulse_t.size() == 3 ? pulse_t[1] - pulse_t[0] : -1, 256);
        chk("t5_gap1", pulse_t.size() == 3 ? pulse_t[2] - pulse_t[1] : -1, 256);
        chk("t5_rate", 32'(rate), 16);

        // disabled: spikes ignored, counters frozen
        en = 1'b0;
        pops0 = pops;
        spikes(5, 10);
        chk("t6_nopush", pops, pops0);
        chk("t6_empty", 32'(fifo_count), 0);
        chk("t6_rate_hold", 32'(rate), 16);
        en = 1'b1;
        got.delete();
        idle(4);
        spikes(1, 10);
        chk("t6_isi", gv(0), 20);

        // reset mid-window with FIFO occupied
        isi_ready = 1'b0;
        spikes(3, 10);
        chk("t6_pre", 32'(fifo_count), 3);
        do_reset();
        isi_ready = 1'b1;
        got.delete();
        spikes(1, 10);
        chk("t6_first", got.size(), 0);
        spikes(1, 10);
        spikes(1, 5);
        chk("t6_after", gv(0), 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
